// File: rtl/edge_slope_setup_pkg.sv
// Shared types and constants for the triangle edge-slope setup stage.
// Slopes are Q10.10 in a 21-bit signed word matching the downstream divider.
package edge_slope_setup_pkg;

  localparam int DIV_W     = 21;
  localparam int COORD_W   = 10;
  localparam int FRAC_BITS = 10;
  localparam int DELTA_W   = COORD_W + 1;

  typedef enum logic [2:0] {
    S_DRAIN,
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUT
  } state_t;

  // Edge i runs from vertex i to vertex (i+1) mod 3.
  typedef enum logic [1:0] {
    EDGE0 = 2'd0,
    EDGE1 = 2'd1,
    EDGE2 = 2'd2
  } edge_idx_t;

  function automatic logic signed [DELTA_W-1:0] coord_delta(
    input logic [COORD_W-1:0] from_c,
    input logic [COORD_W-1:0] to_c
  );
    return $signed({1'b0, to_c}) - $signed({1'b0, from_c});
  endfunction

  function automatic edge_idx_t next_edge(input edge_idx_t e);
    case (e)
      EDGE0:   return EDGE1;
      EDGE1:   return EDGE2;
      default: return EDGE0;
    endcase
  endfunction

endpackage

// File: rtl/edge_slope_setup_if.sv
// Triangle input, slope output and divider-side signals of the setup stage.
// The slave modport is the setup block's view; master is the environment's.
interface edge_slope_setup_if;
  import edge_slope_setup_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [COORD_W-1:0] in_x0, in_y0, in_x1, in_y1, in_x2, in_y2;

  logic               out_valid;
  logic               out_ready;
  logic [DIV_W-1:0]   out_slope0, out_slope1, out_slope2;
  logic [2:0]         out_horiz;
  logic               out_err;

  logic               div_open;
  logic [DIV_W-1:0]   div_dividend;
  logic [DIV_W-1:0]   div_divisor;
  logic               div_finish;
  logic [DIV_W-1:0]   div_quotient;

  modport slave (
    input  in_valid, in_x0, in_y0, in_x1, in_y1, in_x2, in_y2,
    output in_ready,
    output out_valid, out_slope0, out_slope1, out_slope2, out_horiz, out_err,
    input  out_ready,
    output div_open, div_dividend, div_divisor,
    input  div_finish, div_quotient
  );

  modport master (
    output in_valid, in_x0, in_y0, in_x1, in_y1, in_x2, in_y2,
    input  in_ready,
    input  out_valid, out_slope0, out_slope1, out_slope2, out_horiz, out_err,
    output out_ready,
    input  div_open, div_dividend, div_divisor,
    output div_finish, div_quotient
  );

endinterface

// File: rtl/edge_operand_gen.sv
// Registered divider operand formatter: picks the endpoints of edge idx and
// forms dividend = dx <<< FRAC_BITS, divisor = sign-extended dy, plus dy==0.
module edge_operand_gen
  import edge_slope_setup_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  edge_idx_t          idx,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [COORD_W-1:0] x2,
  input  logic [COORD_W-1:0] y2,
  output logic [DIV_W-1:0]   dividend,
  output logic [DIV_W-1:0]   divisor,
  output logic               horiz
);

  logic [COORD_W-1:0]        xa, ya, xb, yb;
  logic signed [DELTA_W-1:0] dx, dy;

  always_comb begin
    xa = x0; ya = y0; xb = x1; yb = y1;
    case (idx)
      EDGE1: begin xa = x1; ya = y1; xb = x2; yb = y2; end
      EDGE2: begin xa = x2; ya = y2; xb = x0; yb = y0; end
      default: ;
    endcase
    dx = coord_delta(xa, xb);
    dy = coord_delta(ya, yb);
  end

  // 11-bit dx shifted by 10 fills the 21-bit word exactly, so no overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dividend <= '0;
      divisor  <= '0;
      horiz    <= 1'b0;
    end else if (load) begin
      dividend <= {dx, {FRAC_BITS{1'b0}}};
      divisor  <= {{(DIV_W-DELTA_W){dy[DELTA_W-1]}}, dy};
      horiz    <= (dy == '0);
    end
  end

endmodule

// File: rtl/edge_slope_setup.sv
// Triangle setup: issues the three edge dx/dy divisions serially and returns
// the Q10.10 inverse slopes over a valid/ready handshake.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   DRAIN   | ignore divider results until any in-flight division retires
//   IDLE    | in_ready high, waiting for a triangle
//   ISSUE   | load operands for edge idx, pulse div_open next cycle
//   WAIT    | wait for div_finish, bounded by TIMEOUT
//   OUT     | slopes presented, held until out_ready
module edge_slope_setup
  import edge_slope_setup_pkg::*;
#(
  parameter int TIMEOUT      = 64,
  parameter int DRAIN_CYCLES = 40
) (
  input logic               clk,
  input logic               rst_n,
  edge_slope_setup_if.slave bus
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);

  state_t             state;
  edge_idx_t          idx;
  logic [TMR_W-1:0]   timer;
  logic [DRN_W-1:0]   drain_cnt;
  logic [COORD_W-1:0] x0, y0, x1, y1, x2, y2;
  logic [DIV_W-1:0]   slope [3];
  logic               gen_horiz;
  logic [DIV_W-1:0]   gen_dividend, gen_divisor;

  edge_operand_gen u_operand_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == S_ISSUE),
    .idx      (idx),
    .x0       (x0),
    .y0       (y0),
    .x1       (x1),
    .y1       (y1),
    .x2       (x2),
    .y2       (y2),
    .dividend (gen_dividend),
    .divisor  (gen_divisor),
    .horiz    (gen_horiz)
  );

  assign bus.div_dividend = gen_dividend;
  assign bus.div_divisor  = gen_divisor;
  assign bus.out_slope0   = slope[0];
  assign bus.out_slope1   = slope[1];
  assign bus.out_slope2   = slope[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_DRAIN;
      idx           <= EDGE0;
      timer         <= '0;
      drain_cnt     <= '0;
      x0 <= '0; y0 <= '0; x1 <= '0; y1 <= '0; x2 <= '0; y2 <= '0;
      slope[0]      <= '0;
      slope[1]      <= '0;
      slope[2]      <= '0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_horiz <= '0;
      bus.out_err   <= 1'b0;
      bus.div_open  <= 1'b0;
    end else begin
      bus.div_open <= 1'b0;
      case (state)
        S_DRAIN: begin
          if (drain_cnt == DRN_LAST) begin
            state        <= S_IDLE;
            bus.in_ready <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end

        S_IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            x0 <= bus.in_x0; y0 <= bus.in_y0;
            x1 <= bus.in_x1; y1 <= bus.in_y1;
            x2 <= bus.in_x2; y2 <= bus.in_y2;
            slope[0]      <= '0;
            slope[1]      <= '0;
            slope[2]      <= '0;
            bus.out_horiz <= '0;
            bus.out_err   <= 1'b0;
            bus.in_ready  <= 1'b0;
            idx           <= EDGE0;
            state         <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          bus.div_open <= 1'b1;
          timer        <= '0;
          state        <= S_WAIT;
        end

        S_WAIT: begin
          bus.out_horiz[idx] <= gen_horiz;
          // A finish on the last timer cycle still counts as a result.
          if (bus.div_finish) begin
            slope[idx] <= bus.div_quotient;
            if (idx == EDGE2) begin
              bus.out_valid <= 1'b1;
              state         <= S_OUT;
            end else begin
              idx   <= next_edge(idx);
              state <= S_ISSUE;
            end
          end else if (timer == TMR_LAST) begin
            for (int i = 0; i < 3; i++) begin
              if (i >= int'(idx)) slope[i] <= '0;
            end
            bus.out_err   <= 1'b1;
            bus.out_valid <= 1'b1;
            state         <= S_OUT;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        S_OUT: begin
          if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (bus.out_err) begin
              // The timed-out division may still complete; drain it first.
              drain_cnt <= '0;
              state     <= S_DRAIN;
            end else begin
              bus.in_ready <= 1'b1;
              state        <= S_IDLE;
            end
          end
        end

        default: state <= S_DRAIN;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_slope_setup.sv
// Bench for edge_slope_setup: table of triangles with hand-computed slopes,
// plus timeout, mid-operation reset and spurious-finish sequences.
module tb_edge_slope_setup;
  import edge_slope_setup_pkg::*;

  localparam int LAT     = 24;
  localparam int TIMEOUT = 64;
  localparam int DRAIN   = 40;
  localparam int LATE    = 80;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  edge_slope_setup_if bus ();

  edge_slope_setup #(.TIMEOUT(TIMEOUT), .DRAIN_CYCLES(DRAIN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Divider model: latency LAT cycles counting the div_open cycle, truncating.
  logic        model_fin = 1'b0;
  logic        spur_fin  = 1'b0;
  logic [20:0] model_q   = '0;
  logic [20:0] spur_q    = '0;
  logic [20:0] pend      = '0;
  int dcnt = 0, open_count = 0, late_issue = -1, last_open_cyc = 0, cyc = 0;

  assign bus.div_finish   = model_fin | spur_fin;
  assign bus.div_quotient = spur_fin ? spur_q : model_q;

  function automatic logic [20:0] divide(input logic [20:0] a, input logic [20:0] b);
    int ia, ib;
    ia = int'($signed(a));
    ib = int'($signed(b));
    if (ib == 0) return '0;
    return 21'(ia / ib);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    model_fin = 1'b0;
    if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) begin
        model_fin = 1'b1;
        model_q   = pend;
      end
    end
    if (bus.div_open === 1'b1) begin
      open_count++;
      last_open_cyc = cyc;
      pend = divide(bus.div_dividend, bus.div_divisor);
      dcnt = (open_count == late_issue) ? LATE - 1 : LAT - 1;
    end
  end

  typedef struct {
    logic [9:0] x0, y0, x1, y1, x2, y2;
    int         s0, s1, s2;
    logic [2:0] horiz;
    int         dvd, dvs;
    int         hold;
    bit         spur;
  } vec_t;

  vec_t   vecs [6];
  integer total = 0, bad = 0;

  task automatic chk(input string name, input integer act, input integer exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_coords(input vec_t v);
    bus.in_x0 = v.x0; bus.in_y0 = v.y0;
    bus.in_x1 = v.x1; bus.in_y1 = v.y1;
    bus.in_x2 = v.x2; bus.in_y2 = v.y2;
  endtask

  task automatic count_to_ready(output int n);
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Accept a triangle and wait for out_valid; lat counts cycles after accept.
  task automatic send(input vec_t v, output int lat, output int opens);
    int n, start_opens;
    count_to_ready(n);
    chk("in_ready_before_send", integer'(bus.in_ready), 1);
    drive_coords(v);
    bus.in_valid = 1'b1;
    start_opens  = open_count;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 600) begin
      @(negedge clk);
      lat++;
    end
    opens = open_count - start_opens;
  endtask

  task automatic check_vec(input vec_t v, input int t);
    chk($sformatf("slope0[%0d]", t), integer'($signed(bus.out_slope0)), v.s0);
    chk($sformatf("slope1[%0d]", t), integer'($signed(bus.out_slope1)), v.s1);
    chk($sformatf("slope2[%0d]", t), integer'($signed(bus.out_slope2)), v.s2);
    chk($sformatf("horiz[%0d]", t), integer'(bus.out_horiz), integer'(v.horiz));
    chk($sformatf("err[%0d]", t), integer'(bus.out_err), 0);
    chk($sformatf("dividend_hold[%0d]", t), integer'($signed(bus.div_dividend)), v.dvd);
    chk($sformatf("divisor_hold[%0d]", t), integer'($signed(bus.div_divisor)), v.dvs);
  endtask

  // Hold out_ready low for `hold` cycles (optionally with a spurious finish),
  // then accept; outputs must match the expected record throughout.
  task automatic release_out(input vec_t v, input int hold, input bit spur,
                             input bit exp_ready);
    bit ok = 1'b1;
    bus.out_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      if (spur && k == hold / 2) begin
        spur_fin = 1'b1;
        spur_q   = 21'h0ABCD;
      end
      @(negedge clk);
      spur_fin = 1'b0;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.div_open !== 1'b0 ||
          integer'($signed(bus.out_slope0)) !== v.s0 ||
          integer'($signed(bus.out_slope1)) !== v.s1 ||
          integer'($signed(bus.out_slope2)) !== v.s2 ||
          bus.out_horiz !== v.horiz) ok = 1'b0;
    end
    if (hold > 0) chk("hold_stable", integer'(ok), 1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("out_valid_after_accept", integer'(bus.out_valid), 0);
    chk("in_ready_after_accept", integer'(bus.in_ready), integer'(exp_ready));
  endtask

  initial begin
    int lat, opens, n;
    bit ok;
    vecs[0] = '{10'd0, 10'd0, 10'd10, 10'd20, 10'd30, 10'd20,
                512, 0, 1536, 3'b010, -30720, -20, 0, 1'b0};
    vecs[1] = '{10'd100, 10'd0, 10'd97, 10'd7, 10'd100, 10'd7,
                -438, 0, 0, 3'b010, 0, -7, 0, 1'b0};
    vecs[2] = '{10'd5, 10'd5, 10'd5, 10'd5, 10'd5, 10'd5,
                0, 0, 0, 3'b111, 0, 0, 50, 1'b0};
    vecs[3] = '{10'd0, 10'd0, 10'd1023, 10'd1, 10'd0, 10'd1023,
                1047552, -1025, 0, 3'b000, 0, -1023, 0, 1'b0};
    vecs[4] = '{10'd1023, 10'd1023, 10'd0, 10'd1023, 10'd512, 10'd0,
                0, -512, 511, 3'b001, 523264, 1023, 8, 1'b1};
    vecs[5] = '{10'd3, 10'd10, 10'd0, 10'd0, 10'd7, 10'd3,
                307, 2389, -585, 3'b000, -4096, 7, 0, 1'b0};

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    drive_coords(vecs[0]);

    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", integer'(bus.in_ready), 0);
    chk("rst_out_valid", integer'(bus.out_valid), 0);
    chk("rst_div_open", integer'(bus.div_open), 0);
    chk("rst_dividend", integer'(bus.div_dividend), 0);
    chk("rst_divisor", integer'(bus.div_divisor), 0);
    chk("rst_slopes", integer'(bus.out_slope0 | bus.out_slope1 | bus.out_slope2), 0);
    chk("rst_horiz_err", integer'({bus.out_horiz, bus.out_err}), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    count_to_ready(n);
    chk("drain_after_reset", n, DRAIN);

    // Table of triangles: slopes, horiz, latency, issue count, held operands.
    for (int i = 0; i < 6; i++) begin
      send(vecs[i], lat, opens);
      chk($sformatf("latency[%0d]", i), lat, 3 * (LAT + 1) + 1);
      chk($sformatf("open_pulses[%0d]", i), opens, 3);
      check_vec(vecs[i], i);
      release_out(vecs[i], vecs[i].hold, vecs[i].spur, 1'b1);
    end

    // Spurious finish while IDLE.
    spur_fin = 1'b1; spur_q = 21'h01234;
    @(negedge clk);
    spur_fin = 1'b0;
    @(negedge clk);
    chk("idle_spur_in_ready", integer'(bus.in_ready), 1);
    chk("idle_spur_out_valid", integer'(bus.out_valid), 0);
    chk("idle_spur_slope2", integer'($signed(bus.out_slope2)), vecs[5].s2);
    send(vecs[0], lat, opens);
    chk("after_spur_opens", opens, 3);
    check_vec(vecs[0], 10);
    release_out(vecs[0], 0, 1'b0, 1'b1);

    // Timeout on edge 1; its result arrives late, inside the drain window.
    late_issue = open_count + 2;
    send(vecs[0], lat, opens);
    chk("timeout_delay", cyc - last_open_cyc, TIMEOUT);
    chk("timeout_opens", opens, 2);
    chk("timeout_err", integer'(bus.out_err), 1);
    chk("timeout_slope0", integer'($signed(bus.out_slope0)), 512);
    chk("timeout_slope1", integer'($signed(bus.out_slope1)), 0);
    chk("timeout_slope2", integer'($signed(bus.out_slope2)), 0);
    release_out(vecs[0], 0, 1'b0, 1'b0);
    n = 0; ok = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
      if (bus.out_valid !== 1'b0 || bus.div_open !== 1'b0 ||
          integer'($signed(bus.out_slope1)) !== 0) ok = 1'b0;
    end
    chk("timeout_drain", n, DRAIN);
    chk("drain_ignores_late_finish", integer'(ok), 1);
    late_issue = -1;

    // Reset while waiting on edge 1.
    drive_coords(vecs[5]);
    n = open_count;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (open_count < n + 2 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk("reached_edge1_wait", open_count - n, 2);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_slope0", integer'(bus.out_slope0), 0);
    chk("midrst_dividend", integer'(bus.div_dividend), 0);
    chk("midrst_divisor", integer'(bus.div_divisor), 0);
    chk("midrst_ctrl", integer'({bus.in_ready, bus.out_valid, bus.div_open, bus.out_err}), 0);
    chk("midrst_horiz", integer'(bus.out_horiz), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    count_to_ready(n);
    chk("midrst_drain", n, DRAIN);
    chk("midrst_no_output", integer'(bus.out_valid), 0);
    send(vecs[5], lat, opens);
    chk("post_rst_latency", lat, 3 * (LAT + 1) + 1);
    check_vec(vecs[5], 20);
    release_out(vecs[5], 0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/edge_slope_setup.md
Name: edge_slope_setup

Overview:
Triangle-setup stage that sits directly upstream of the 21-bit signed divider wrapper in the render pipeline.
- Accepts one triangle (three screen-space vertices) per transaction.
- Computes, for each edge, the fixed-point inverse slope dx/dy. Each division is issued serially to the divider, one at a time.
- Collects the three quotients and presents them with a valid/ready handshake to the rasterizer edge walker.

Parameters:
- COORD_W, 10: unsigned vertex coordinate width (0..1023).
- FRAC_BITS, 10: fractional bits of the slope; dividend = dx <<< FRAC_BITS.
- TIMEOUT, 64: max cycles waited for div_finish after an issue.
- DRAIN_CYCLES, 40: cycles to ignore div_finish after reset or timeout; must be at least the divider latency.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  triangle present
- in_ready  out  1  block accepts triangle
- in_x0, in_y0, in_x1, in_y1, in_x2, in_y2  in  COORD_W each  vertex coordinates
- out_valid  out  1  slopes valid
- out_ready  in  1  consumer accepts slopes
- out_slope0, out_slope1, out_slope2  out  21 each  signed Q10.10 slopes of edges v0->v1, v1->v2, v2->v0
- out_horiz  out  3  bit i set when edge i has dy==0
- out_err  out  1  divider timeout occurred for this triangle
- div_open  out  1  one-cycle issue strobe to divider
- div_dividend  out  21  signed dividend
- div_divisor  out  21  signed divisor
- div_finish  in  1  divider result strobe
- div_quotient  in  21  signed quotient (0 when divisor is 0)

Behaviour:
- Reset (async, rst_n=0):
  - State goes to DRAIN with the drain counter at 0.
  - in_ready=0, out_valid=0, div_open=0.
  - div_dividend, div_divisor, all slopes, out_horiz and out_err are 0.
- Operand formation for edge i (from vertex a to vertex b):
  - dx = xb - xa and dy = yb - ya, each an 11-bit signed value.
  - div_dividend = sign-extended dx shifted left by FRAC_BITS (exactly 21 bits, no overflow).
  - div_divisor = sign-extended dy.
  - out_horiz[i] = (dy==0), computed locally, not by the divider.
- States:
  - DRAIN:
    - Counter increments every cycle; div_finish is ignored.
    - When the counter reaches DRAIN_CYCLES-1, go to IDLE.
  - IDLE:
    - in_ready=1.
    - On in_valid&&in_ready: latch all six coordinates, clear out_err, set idx=0, go to ISSUE.
  - ISSUE:
    - Register the operands for edge idx and pulse div_open=1 for exactly one cycle.
    - Clear the timer and go to WAIT.
  - WAIT:
    - On div_finish: capture div_quotient into slope[idx]. If idx==2 go to OUT, else increment idx and go to ISSUE.
    - Otherwise increment the timer. When the timer reaches TIMEOUT-1: set out_err=1, set the remaining uncaptured slopes to 0, go to OUT.
  - OUT:
    - out_valid=1; all outputs held stable until out_ready.
    - On out_valid&&out_ready: go to DRAIN if out_err, else IDLE.
- Handshake rules:
  - in_ready is asserted only in IDLE, so at most one triangle is in flight and no overlap with OUT is possible.
  - out_valid is never withdrawn before it is accepted.
- Timing:
  - div_dividend and div_divisor are registered and hold their last value outside ISSUE.
  - Latency with a divider latency of L cycles: accept, then 3*(L+1)+1 cycles until out_valid.
- Boundary conditions:
  - div_finish seen in IDLE, ISSUE, OUT or DRAIN: ignored, no state change.
  - div_finish in the same cycle the timer reaches its limit: the finish wins and no error is raised.
  - dy==0: the divider returns 0; the slope is 0 and the horiz bit is set.
  - Degenerate triangle (all vertices equal): all slopes 0, out_horiz=3'b111.
  - Reset mid-WAIT: abort immediately. A stale div_finish from the aborted operation falls inside the DRAIN window and is discarded.
  - Quotient: signed, truncated toward zero, taken verbatim from the divider.

Decomposition:
- Shared package holds:
  - the state enum (DRAIN, IDLE, ISSUE, WAIT, OUT);
  - constants DIV_W=21, COORD_W and FRAC_BITS;
  - the edge index encoding 0..2.
- One natural sub-module: edge_operand_gen. It is the registered operand formatter: it takes the latched vertices and idx, and produces div_dividend, div_divisor and the horiz bit.
- The FSM, timer, drain counter and result registers live in edge_slope_setup.

Test Plan:
Bench uses a divider model with latency 24 and truncating signed division.
1. Basic triangle:
   - Stimulus: v0=(0,0), v1=(10,20), v2=(30,20).
   - Required: out_slope0=512, out_slope1=0 with out_horiz=3'b010, out_slope2=(-30720)/(-20)=1536, out_err=0.
   - Required: out_valid rises 3*25+1 cycles after accept.
2. Negative slope and truncation:
   - Stimulus: v0=(100,0), v1=(97,7), v2=(100,7).
   - Required: out_slope0 = -3072/7 = -438 (21-bit two's complement), out_horiz=3'b010, out_slope2 = 0 (dx=0, dy=-7).
3. Backpressure:
   - Stimulus: hold out_ready=0 for 50 cycles after out_valid.
   - Required: outputs stable, in_ready=0 throughout; on acceptance in_ready=1 the next cycle.
4. Timeout:
   - Stimulus: the model suppresses the second div_finish.
   - Required: out_err=1 TIMEOUT cycles after the second issue; out_slope1=out_slope2=0.
   - Required: after acceptance, in_ready stays 0 for DRAIN_CYCLES, and a late div_finish in that window changes nothing.
5. Reset mid-operation:
   - Stimulus: assert rst_n=0 for 3 cycles while in WAIT on edge 1.
   - Required: all outputs 0 immediately; the stale div_finish is ignored; in_ready=1 after DRAIN_CYCLES.
   - Required: the next triangle produces correct slopes.
6. Spurious finish:
   - Stimulus: pulse div_finish in IDLE and during OUT.
   - Required: no state or output change; div_open pulses exactly 3 times per triangle.
